control_sequencer: RTL and testbench
====================================

# control_sequencer

Control unit for the Mini-SRC datapath. It generates the per-cycle control strobes that a testbench would otherwise drive by hand: fetch (T0–T2) and three-register ALU execute (T3–T5). It reads the datapath's IR contents and a memory-ready flag. Its one-hot register-select vectors and strobes feed the datapath's individual Rin/Rout/PCout/… inputs through a thin wiring wrapper.

## Interface
Parameters:
- None. All constants live in the package.

Ports:
- Clock  in  1  single system clock; all state changes on rising edge.
- Clear  in  1  asynchronous, active-high reset.
- IR  in  32  current instruction-register contents from the datapath.
- MemReady  in  1  memory has valid data on Mdatain this cycle.
- Rin  out  16  one-hot register load enables, R0..R15.
- Rout  out  16  one-hot register bus drivers, R0..R15.
- PCout, MARin, IncPC, PCin  out  1 each  PC/MAR strobes.
- Read, MDRin, MDRout, IRin  out  1 each  memory/IR strobes.
- Yin, ZLowin, ZLowout  out  1 each  ALU operand/result strobes.
- OP  out  5  ALU operation code.
- Run  out  1  high unless halted.

## Operation
- IR fields: opcode IR[31:27], Ra IR[26:23] (dest), Rb IR[22:19], Rc IR[18:15].
- ALU class is opcodes 5'd3..5'd10. Mapping is ALU OP = opcode + 1 (add 00011→00100, shr 00111→01000). Halt is 5'b11011. Every other opcode is a NOP.
- States: S_RST, T0, T1, T2, T3, T4, T5, HALT.
- S_RST: all outputs 0, Run=1 once Clear is low. Next state T0.
- T0: PCout, MARin, IncPC. Next state T1.
- T1: Read held for the whole state. MDRin and PCin are asserted only in a cycle where MemReady=1. Stay in T1 while MemReady=0, else go to T2.
- T2: MDRout, IRin. Next state T3 unconditionally, because IR is loaded on this edge.
- T3, ALU class: Rout[Rb], Yin. Next state T4.
- T3, halt: no strobes. Next state HALT.
- T3, NOP: no strobes. Next state T0.
- T4: Rout[Rc], ZLowin, OP = mapped code. Next state T5.
- T5: ZLowout, Rin[Ra]. Next state T0. A write to R0 is permitted.
- HALT: all strobes 0, Run=0. Leave only via Clear.
- OP is 0 in every state except T4.
- Rin and Rout are never both non-zero in the same cycle. Each is at most one-hot.

## Timing
- Moore outputs are decoded combinationally from the state register, with two exceptions:
  - MDRin and PCin are additionally qualified by MemReady.
  - T3 strobes are qualified by the IR opcode class.
- Reset values:
  - State = S_RST.
  - Every output = 0, except Run.
  - Run = 0 while Clear is high, 1 in S_RST after Clear falls.
- Clear asserted mid-instruction (any state) forces S_RST asynchronously. All strobes drop within the same delta; there is no partial write-back.
- First rising edge after Clear deasserts: S_RST→T0.
- Latency with MemReady tied high:
  - ALU instruction: 6 cycles, T0 to T5.
  - NOP: 4 cycles.
  - Halt: 4 cycles to HALT.
- Each MemReady-low cycle in T1 adds one cycle. PCin fires exactly once per fetch.
- IR changes outside T2→T3 are not expected. If they occur, T3/T4/T5 use the live IR value.

## Structure
- Package mini_src_ctrl_pkg holds:
  - state enum/encoding;
  - opcode constants (ALU_LO=3, ALU_HI=10, HALT=27);
  - the opcode→ALU OP function;
  - the IR field bit positions.
- Sub-module reg_select_decoder: a 4-to-16 one-hot decoder with an enable. There are three instances: Rb and Rc (OR-combined onto Rout by state), and Ra (onto Rin).

## Test plan
- Pulse Clear in T4 of an ALU instruction. Required: all outputs 0 immediately; T0 strobes appear one edge after Clear falls.
- IR=0x389A8000 (shr R1,R3,R5), MemReady=1. Required:
  - T3: Rout=0x0008, Yin.
  - T4: Rout=0x0020, OP=01000, ZLowin.
  - T5: ZLowout, Rin=0x0002.
  - Then T0.
- IR=0x19230000 (add R2,R4,R6). Required:
  - T3: Rout=0x0010.
  - T4: Rout=0x0040, OP=00100.
  - T5: Rin=0x0004.
- Hold MemReady low for 3 cycles in T1. Required: Read high for 4 cycles; MDRin and PCin high only in the 4th.
- IR=0x80000000 (opcode 10000). Required: no Yin/ZLowin/Rin/Rout in T3; next state T0; 4-cycle instruction.
- IR=0xD8000000 (halt). Required: Run=0 after T3; all strobes stay 0 for 10+ cycles; Clear restarts at T0.

Source files
------------

// File: rtl/mini_src_ctrl_pkg.sv
// Shared definitions for the Mini-SRC control sequencer.
// Holds the state encoding, opcode constants, IR field positions and the
// opcode-to-ALU-operation mapping used by the sequencer and its decoders.
package mini_src_ctrl_pkg;

  localparam int unsigned IR_W      = 32;
  localparam int unsigned OPC_W     = 5;
  localparam int unsigned REG_SEL_W = 4;
  localparam int unsigned NUM_REGS  = 16;

  // IR field bit positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned RC_LSB  = 15;

  // Opcode constants
  localparam logic [OPC_W-1:0] ALU_LO = 5'd3;
  localparam logic [OPC_W-1:0] ALU_HI = 5'd10;
  localparam logic [OPC_W-1:0] HALT   = 5'd27;

  typedef enum logic [2:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_e;

  function automatic logic is_alu(input logic [OPC_W-1:0] opcode);
    return (opcode >= ALU_LO) && (opcode <= ALU_HI);
  endfunction

  // ALU operation codes sit one above the matching instruction opcode
  function automatic logic [OPC_W-1:0] alu_op(input logic [OPC_W-1:0] opcode);
    return OPC_W'(opcode + OPC_W'(1));
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath wiring wrapper.
// master: sequencer side (reads IR/MemReady, drives strobes, OP and Run).
// slave : datapath side (drives IR/MemReady, consumes strobes).
interface control_sequencer_if;
  import mini_src_ctrl_pkg::*;

  logic [IR_W-1:0]     IR;
  logic                MemReady;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic                PCout;
  logic                MARin;
  logic                IncPC;
  logic                PCin;
  logic                Read;
  logic                MDRin;
  logic                MDRout;
  logic                IRin;
  logic                Yin;
  logic                ZLowin;
  logic                ZLowout;
  logic [OPC_W-1:0]    OP;
  logic                Run;

  modport master (
    input  IR, MemReady,
    output Rin, Rout, PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
           Yin, ZLowin, ZLowout, OP, Run
  );

  modport slave (
    output IR, MemReady,
    input  Rin, Rout, PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
           Yin, ZLowin, ZLowout, OP, Run
  );

endinterface

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot register select decoder with enable.
// Ports: sel (register number), en (decode enable), onehot_c (one-hot
// select, all zero when disabled).
module reg_select_decoder
  import mini_src_ctrl_pkg::*;
(
  input  logic [REG_SEL_W-1:0] sel,
  input  logic                 en,
  output logic [NUM_REGS-1:0]  onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) begin
      onehot_c[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Mini-SRC control unit: fetch (T0-T2) and three-register ALU execute
// (T3-T5), plus halt. Outputs are decoded from the state register, so an
// asynchronous Clear drops every strobe immediately.
// Ports: Clock, Clear (async, active high), bus (master modport: IR and
// MemReady in; Rin/Rout one-hot, PC/MAR/memory/ALU strobes, OP, Run out).
module control_sequencer
  import mini_src_ctrl_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Clear,
  control_sequencer_if.master  bus
);

  state_e state_q;
  state_e state_d;

  logic [OPC_W-1:0]     opcode;
  logic [REG_SEL_W-1:0] ra;
  logic [REG_SEL_W-1:0] rb;
  logic [REG_SEL_W-1:0] rc;

  logic pc_out_c, mar_in_c, inc_pc_c, pc_in_c;
  logic read_c, mdr_in_c, mdr_out_c, ir_in_c;
  logic y_in_c, zlow_in_c, zlow_out_c;
  logic ra_en_c, rb_en_c, rc_en_c;
  logic [OPC_W-1:0] op_c;

  logic [NUM_REGS-1:0] ra_onehot_c;
  logic [NUM_REGS-1:0] rb_onehot_c;
  logic [NUM_REGS-1:0] rc_onehot_c;

  // Fields are taken from the live IR; it is only expected to change at T2->T3
  assign opcode = bus.IR[OPC_MSB:OPC_LSB];
  assign ra     = bus.IR[RA_MSB:RA_LSB];
  assign rb     = bus.IR[RB_MSB:RB_LSB];
  assign rc     = bus.IR[RC_MSB:RC_LSB];

  // Low IR bits carry fields this unit does not decode
  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.IR[RC_LSB-1:0];

  // State register
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d    = state_q;
    pc_out_c   = 1'b0;
    mar_in_c   = 1'b0;
    inc_pc_c   = 1'b0;
    pc_in_c    = 1'b0;
    read_c     = 1'b0;
    mdr_in_c   = 1'b0;
    mdr_out_c  = 1'b0;
    ir_in_c    = 1'b0;
    y_in_c     = 1'b0;
    zlow_in_c  = 1'b0;
    zlow_out_c = 1'b0;
    ra_en_c    = 1'b0;
    rb_en_c    = 1'b0;
    rc_en_c    = 1'b0;
    op_c       = '0;

    case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        pc_out_c = 1'b1;
        mar_in_c = 1'b1;
        inc_pc_c = 1'b1;
        state_d  = S_T1;
      end
      S_T1: begin
        // Read is held while waiting; the loads fire only in the ready cycle
        read_c = 1'b1;
        if (bus.MemReady) begin
          mdr_in_c = 1'b1;
          pc_in_c  = 1'b1;
          state_d  = S_T2;
        end
      end
      S_T2: begin
        mdr_out_c = 1'b1;
        ir_in_c   = 1'b1;
        state_d   = S_T3;
      end
      S_T3: begin
        if (is_alu(opcode)) begin
          rb_en_c = 1'b1;
          y_in_c  = 1'b1;
          state_d = S_T4;
        end else if (opcode == HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_T0;
        end
      end
      S_T4: begin
        rc_en_c   = 1'b1;
        zlow_in_c = 1'b1;
        op_c      = alu_op(opcode);
        state_d   = S_T5;
      end
      S_T5: begin
        ra_en_c    = 1'b1;
        zlow_out_c = 1'b1;
        state_d    = S_T0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  reg_select_decoder u_ra_dec (
    .sel      (ra),
    .en       (ra_en_c),
    .onehot_c (ra_onehot_c)
  );

  reg_select_decoder u_rb_dec (
    .sel      (rb),
    .en       (rb_en_c),
    .onehot_c (rb_onehot_c)
  );

  reg_select_decoder u_rc_dec (
    .sel      (rc),
    .en       (rc_en_c),
    .onehot_c (rc_onehot_c)
  );

  // Rb and Rc are enabled in different states, so the OR stays one-hot
  assign bus.Rout    = rb_onehot_c | rc_onehot_c;
  assign bus.Rin     = ra_onehot_c;
  assign bus.PCout   = pc_out_c;
  assign bus.MARin   = mar_in_c;
  assign bus.IncPC   = inc_pc_c;
  assign bus.PCin    = pc_in_c;
  assign bus.Read    = read_c;
  assign bus.MDRin   = mdr_in_c;
  assign bus.MDRout  = mdr_out_c;
  assign bus.IRin    = ir_in_c;
  assign bus.Yin     = y_in_c;
  assign bus.ZLowin  = zlow_in_c;
  assign bus.ZLowout = zlow_out_c;
  assign bus.OP      = op_c;
  // Run follows Clear directly so it is low for the whole reset pulse
  assign bus.Run     = !Clear && (state_q != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle comparison against an
// instruction-level trace model, a table of directed instructions, and
// hand-written sequences for Clear mid-instruction and halt/restart.
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        pcout;
    logic        marin;
    logic        incpc;
    logic        pcin;
    logic        read;
    logic        mdrin;
    logic        mdrout;
    logic        irin;
    logic        yin;
    logic        zlowin;
    logic        zlowout;
    logic [4:0]  op;
    logic        run;
  } obs_t;

  typedef struct {
    logic [31:0] ir;
    int          nlow;
    bit          alu;
    logic [15:0] t3_rout;
    logic [15:0] t4_rout;
    logic [4:0]  op;
    logic [15:0] t5_rin;
  } vec_t;

  logic Clock = 1'b0;
  logic Clear;

  control_sequencer_if bus();

  control_sequencer dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];

  function automatic obs_t sample_obs();
    obs_t o;
    o.rin     = bus.Rin;
    o.rout    = bus.Rout;
    o.pcout   = bus.PCout;
    o.marin   = bus.MARin;
    o.incpc   = bus.IncPC;
    o.pcin    = bus.PCin;
    o.read    = bus.Read;
    o.mdrin   = bus.MDRin;
    o.mdrout  = bus.MDRout;
    o.irin    = bus.IRin;
    o.yin     = bus.Yin;
    o.zlowin  = bus.ZLowin;
    o.zlowout = bus.ZLowout;
    o.op      = bus.OP;
    o.run     = bus.Run;
    return o;
  endfunction

  function automatic obs_t idle(input logic run);
    obs_t o;
    o     = '0;
    o.run = run;
    return o;
  endfunction

  function automatic obs_t t0_obs();
    obs_t o;
    o       = idle(1'b1);
    o.pcout = 1'b1;
    o.marin = 1'b1;
    o.incpc = 1'b1;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Instruction-level model: list of expected outputs, one entry per cycle
  task automatic build_expected(input logic [31:0] ir, input int nlow, input int halt_cycles);
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    obs_t o;
    opc = ir[31:27];
    ra  = ir[26:23];
    rb  = ir[22:19];
    rc  = ir[18:15];
    exp_q.delete();
    exp_q.push_back(t0_obs());
    for (int i = 0; i < nlow; i++) begin
      o = idle(1'b1); o.read = 1'b1;
      exp_q.push_back(o);
    end
    o = idle(1'b1); o.read = 1'b1; o.mdrin = 1'b1; o.pcin = 1'b1;
    exp_q.push_back(o);
    o = idle(1'b1); o.mdrout = 1'b1; o.irin = 1'b1;
    exp_q.push_back(o);
    if (opc >= 5'd3 && opc <= 5'd10) begin
      o = idle(1'b1); o.rout = 16'd1 << rb; o.yin = 1'b1;
      exp_q.push_back(o);
      o = idle(1'b1); o.rout = 16'd1 << rc; o.zlowin = 1'b1; o.op = 5'(opc + 5'd1);
      exp_q.push_back(o);
      o = idle(1'b1); o.rin = 16'd1 << ra; o.zlowout = 1'b1;
      exp_q.push_back(o);
    end else begin
      exp_q.push_back(idle(1'b1));
      if (opc == 5'd27) begin
        for (int i = 0; i < halt_cycles; i++) exp_q.push_back(idle(1'b0));
      end
    end
  endtask

  // Starts in T0; drives MemReady low for nlow T1 cycles, random elsewhere
  task automatic run_instr(input logic [31:0] ir, input int nlow, input int halt_cycles,
                           input string tag);
    obs_t o;
    build_expected(ir, nlow, halt_cycles);
    obs_q.delete();
    bus.IR = ir;
    foreach (exp_q[k]) begin
      if (k >= 1 && k <= nlow)  bus.MemReady = 1'b0;
      else if (k == nlow + 1)   bus.MemReady = 1'b1;
      else                      bus.MemReady = 1'($urandom_range(0, 1));
      @(negedge Clock);
      o = sample_obs();
      obs_q.push_back(o);
      check_obs($sformatf("%s cyc%0d", tag, k), o, exp_q[k]);
      @(posedge Clock);
      #1;
    end
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    obs_t o;
    int   reads, pcins;

    vecs[0] = '{32'h389A8000, 0, 1'b1, 16'h0008, 16'h0020, 5'b01000, 16'h0002};
    vecs[1] = '{32'h19230000, 0, 1'b1, 16'h0010, 16'h0040, 5'b00100, 16'h0004};
    vecs[2] = '{32'h389A8000, 3, 1'b1, 16'h0008, 16'h0020, 5'b01000, 16'h0002};
    vecs[3] = '{32'h80000000, 0, 1'b0, 16'h0000, 16'h0000, 5'b00000, 16'h0000};
    vecs[4] = '{32'h507B8000, 1, 1'b1, 16'h8000, 16'h0080, 5'b01011, 16'h0001};
    vecs[5] = '{32'h10000000, 2, 1'b0, 16'h0000, 16'h0000, 5'b00000, 16'h0000};
    vecs[6] = '{32'h58000000, 0, 1'b0, 16'h0000, 16'h0000, 5'b00000, 16'h0000};

    // Reset state
    Clear        = 1'b1;
    bus.IR       = '0;
    bus.MemReady = 1'b0;
    #12;
    check_obs("reset held", sample_obs(), idle(1'b0));
    @(negedge Clock);
    Clear = 1'b0;
    #1;
    check_obs("S_RST after clear", sample_obs(), idle(1'b1));
    @(posedge Clock);
    #1;
    check_obs("first T0", sample_obs(), t0_obs());

    // Directed table
    foreach (vecs[i]) begin
      run_instr(vecs[i].ir, vecs[i].nlow, 0, $sformatf("vec%0d", i));
      reads = 0;
      pcins = 0;
      foreach (obs_q[k]) begin
        reads += int'(obs_q[k].read);
        pcins += int'(obs_q[k].pcin);
      end
      check_val($sformatf("vec%0d read cycles", i), 32'(reads), 32'(vecs[i].nlow + 1));
      check_val($sformatf("vec%0d pcin count", i), 32'(pcins), 32'd1);
      check_val($sformatf("vec%0d mdrin ready cycle", i),
                32'(obs_q[vecs[i].nlow + 1].mdrin), 32'd1);
      o = obs_q[vecs[i].nlow + 3];
      check_val($sformatf("vec%0d T3 rout", i), 32'(o.rout), 32'(vecs[i].t3_rout));
      check_val($sformatf("vec%0d T3 yin", i), 32'(o.yin), 32'(vecs[i].alu));
      if (vecs[i].alu) begin
        o = obs_q[vecs[i].nlow + 4];
        check_val($sformatf("vec%0d T4 rout", i), 32'(o.rout), 32'(vecs[i].t4_rout));
        check_val($sformatf("vec%0d T4 op", i), 32'(o.op), 32'(vecs[i].op));
        o = obs_q[vecs[i].nlow + 5];
        check_val($sformatf("vec%0d T5 rin", i), 32'(o.rin), 32'(vecs[i].t5_rin));
      end
      #1;
      check_obs($sformatf("vec%0d next is T0", i), sample_obs(), t0_obs());
    end

    // Clear pulsed in T4 of an ALU instruction
    bus.IR       = 32'h389A8000;
    bus.MemReady = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
    check_val("T4 before clear op", 32'(bus.OP), 32'd8);
    #1;
    Clear = 1'b1;
    #1;
    check_obs("clear in T4 drops outputs", sample_obs(), idle(1'b0));
    @(negedge Clock);
    Clear = 1'b0;
    #1;
    check_obs("S_RST after mid-clear", sample_obs(), idle(1'b1));
    @(posedge Clock);
    #1;
    check_obs("T0 after mid-clear", sample_obs(), t0_obs());

    // Randomized instructions against the model
    for (int n = 0; n < 40; n++) begin
      logic [4:0]  opc;
      logic [31:0] rnd;
      rnd = $urandom;
      if ($urandom_range(0, 9) < 6) begin
        opc = 5'($urandom_range(3, 10));
      end else begin
        do opc = 5'($urandom_range(0, 31)); while (opc == 5'd27);
      end
      run_instr({opc, rnd[26:0]}, int'($urandom_range(0, 3)), 0, $sformatf("rnd%0d", n));
    end

    // Halt, then restart via Clear
    run_instr({5'd27, 27'($urandom)}, 1, 12, "halt");
    Clear = 1'b1;
    #1;
    check_obs("clear in HALT", sample_obs(), idle(1'b0));
    @(negedge Clock);
    Clear = 1'b0;
    #1;
    check_obs("S_RST after halt", sample_obs(), idle(1'b1));
    @(posedge Clock);
    #1;
    run_instr(32'h19230000, 0, 0, "after halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
